sp_ingress_fifo: RTL and testbench

//   Per-requester ingress queue placed directly upstream of the strict-priority

---
 rtl/sp_ingress_fifo.sv | 77 +++++++
 tb/tb_sp_ingress_fifo.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ingress_fifo.sv
// sp_ingress_fifo: per-requester first-word-fall-through ingress queue
// feeding one lane of the strict-priority arbiter.
module sp_ingress_fifo #(
  parameter int DATA_BITWIDTH = 10,
  parameter int DEPTH         = 4,
  parameter int AFULL_THRESH  = 3
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     Flush,
  input  logic                     InVld,
  input  logic [DATA_BITWIDTH-1:0] InData,
  output logic                     InRdy,
  output logic                     OutVld,
  output logic [DATA_BITWIDTH-1:0] OutData,
  input  logic                     OutRdy,
  output logic [$clog2(DEPTH):0]   Level,
  output logic                     AlmostFull
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_BITWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LW-1:0]            level;
  logic                     push;
  logic                     pop;

  // Flags come from the registered count only, so OutRdy never
  // reaches InRdy combinationally; a pop while full frees the
  // slot for the following cycle.
  assign InRdy      = (level != LW'(DEPTH));
  assign OutVld     = (level != '0);
  assign AlmostFull = (level >= LW'(AFULL_THRESH));
  assign Level      = level;

  // Storage is not reset, so the head is masked to zero while empty.
  assign OutData = OutVld ? mem[rd_ptr] : '0;

  assign push = InVld & InRdy;
  assign pop  = OutVld & OutRdy;

  // Storage write; a flushing cycle drops the push.
  always_ff @(posedge sys_clk) begin
    if (push && !Flush) begin
      mem[wr_ptr] <= InData;
    end
  end

  // Pointers wrap by natural overflow; level tracks the entry count.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LW'(1);
      end else if (pop && !push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sp_ingress_fifo.sv
// tb_sp_ingress_fifo: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_sp_ingress_fifo;

  localparam int W     = 10;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;

  logic         sys_clk = 1'b0;
  logic         rst;
  logic         Flush;
  logic         InVld;
  logic [W-1:0] InData;
  logic         InRdy;
  logic         OutVld;
  logic [W-1:0] OutData;
  logic         OutRdy;
  logic [2:0]   Level;
  logic         AlmostFull;

  int tests_run = 0;
  int fails     = 0;

  logic [W-1:0] q [$];

  sp_ingress_fifo #(
    .DATA_BITWIDTH(W),
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFT)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .Flush(Flush),
    .InVld(InVld),
    .InData(InData),
    .InRdy(InRdy),
    .OutVld(OutVld),
    .OutData(OutData),
    .OutRdy(OutRdy),
    .Level(Level),
    .AlmostFull(AlmostFull)
  );

  always #5 sys_clk = ~sys_clk;

  // One clock edge; the model applies the queue rules to the
  // inputs seen at the edge, then outputs are sampled 1ns later.
  task automatic tick();
    bit push;
    bit pop;
    @(posedge sys_clk);
    if (rst || Flush) begin
      q.delete();
    end else begin
      push = InVld && (q.size() < DEPTH);
      pop  = OutRdy && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(InData);
    end
    #1;
  endtask

  task automatic drain();
    InVld  = 1'b0;
    OutRdy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    OutRdy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Flush = 1'b0; InVld = 1'b0;
    InData = '0; OutRdy = 1'b0;
    #2;
    tests_run++;
    if (Level !== 3'd0 || OutVld !== 1'b0 || InRdy !== 1'b1 ||
        AlmostFull !== 1'b0 || OutData !== '0) begin
      fails++;
      $display("FAIL reset_state lvl=%0d vld=%b rdy=%b af=%b dat=%h",
               Level, OutVld, InRdy, AlmostFull, OutData);
    end
    tick();
    rst = 1'b0;
    InVld = 1'b1; InData = 10'h003; tick();
    InData = 10'h007; tick();
    InVld = 1'b0;
    tests_run++;
    if (Level !== 3'd2) begin
      fails++;
      $display("FAIL pre_reset_level got=%0d exp=2", Level);
    end
    #3;
    rst = 1'b1;
    q.delete();
    #1;
    tests_run++;
    if (Level !== 3'd0 || OutVld !== 1'b0 || InRdy !== 1'b1) begin
      fails++;
      $display("FAIL async_reset lvl=%0d vld=%b rdy=%b exp 0/0/1",
               Level, OutVld, InRdy);
    end
    #1;
    rst = 1'b0;
    InVld = 1'b1; InData = 10'h155;
    tick();
    InVld = 1'b0;
    tests_run++;
    if (OutVld !== 1'b1 || OutData !== 10'h155 || Level !== 3'd1) begin
      fails++;
      $display("FAIL post_reset_push vld=%b dat=%h lvl=%0d exp 1/155/1",
               OutVld, OutData, Level);
    end
    drain();
  endtask

  task automatic test_fill();
    OutRdy = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      InVld = 1'b1; InData = W'(i);
      tick();
      tests_run++;
      if (Level !== 3'(i) || AlmostFull !== (i >= AFT) ||
          InRdy !== (i != DEPTH)) begin
        fail_fill(i);
      end
    end
    InData = 10'h005;
    tick();
    InVld = 1'b0;
    tests_run++;
    if (Level !== 3'd4 || InRdy !== 1'b0) begin
      fails++;
      $display("FAIL fill_overflow lvl=%0d rdy=%b exp 4/0", Level, InRdy);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      tests_run++;
      if (OutVld !== 1'b1 || OutData !== W'(i)) begin
        fails++;
        $display("FAIL fill_drain got=%h exp=%h vld=%b", OutData, W'(i), OutVld);
      end
      OutRdy = 1'b1; tick(); OutRdy = 1'b0;
    end
    tests_run++;
    if (Level !== 3'd0 || OutVld !== 1'b0) begin
      fails++;
      $display("FAIL fill_empty lvl=%0d vld=%b exp 0/0", Level, OutVld);
    end
  endtask

  task automatic fail_fill(int i);
    fails++;
    $display("FAIL fill_step%0d lvl=%0d af=%b rdy=%b", i, Level, AlmostFull, InRdy);
  endtask

  task automatic test_full_pop();
    OutRdy = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      InVld = 1'b1; InData = W'(32'h10 + i); tick();
    end
    InData = 10'h0AB; OutRdy = 1'b1;
    tick();
    tests_run++;
    if (Level !== 3'd3 || OutData !== 10'h012) begin
      fails++;
      $display("FAIL full_pop lvl=%0d dat=%h exp 3/012", Level, OutData);
    end
    OutRdy = 1'b0;
    tick();
    InVld = 1'b0;
    tests_run++;
    if (Level !== 3'd4) begin
      fails++;
      $display("FAIL full_refill lvl=%0d exp=4", Level);
    end
    for (int i = 0; i < DEPTH; i++) begin
      tests_run++;
      if (OutData !== q[0]) begin
        fails++;
        $display("FAIL full_order got=%h exp=%h", OutData, q[0]);
      end
      OutRdy = 1'b1; tick(); OutRdy = 1'b0;
    end
  endtask

  task automatic test_streaming();
    InVld = 1'b1; OutRdy = 1'b1; InData = '0;
    tick();
    for (int i = 1; i < 20; i++) begin
      tests_run++;
      if (OutVld !== 1'b1 || OutData !== W'(i - 1) || Level !== 3'd1) begin
        fails++;
        $display("FAIL stream_%0d vld=%b dat=%h lvl=%0d exp 1/%h/1",
                 i, OutVld, OutData, Level, W'(i - 1));
      end
      InData = W'(i);
      tick();
    end
    InVld = 1'b0;
    tests_run++;
    if (OutData !== 10'd19 || Level !== 3'd1) begin
      fails++;
      $display("FAIL stream_last dat=%h lvl=%0d exp 013/1", OutData, Level);
    end
    drain();
  endtask

  task automatic test_backpressure();
    OutRdy = 1'b0;
    InVld = 1'b1; InData = 10'h2AA; tick();
    InData = 10'h111; tick();
    InVld = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (OutVld !== 1'b1 || OutData !== 10'h2AA) begin
        fails++;
        $display("FAIL hold_%0d vld=%b dat=%h exp 1/2aa", i, OutVld, OutData);
      end
      tick();
    end
    OutRdy = 1'b1; tick(); OutRdy = 1'b0;
    tests_run++;
    if (Level !== 3'd1 || OutData !== 10'h111) begin
      fails++;
      $display("FAIL hold_pop lvl=%0d dat=%h exp 1/111", Level, OutData);
    end
    drain();
  endtask

  task automatic test_flush();
    OutRdy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      InVld = 1'b1; InData = W'(32'h30 + i); tick();
    end
    tests_run++;
    if (Level !== 3'd3) begin
      fails++;
      $display("FAIL flush_pre lvl=%0d exp=3", Level);
    end
    Flush = 1'b1; InVld = 1'b1; OutRdy = 1'b1; InData = 10'h3FF;
    tick();
    Flush = 1'b0; InVld = 1'b0; OutRdy = 1'b0;
    tests_run++;
    if (Level !== 3'd0 || OutVld !== 1'b0 || InRdy !== 1'b1) begin
      fails++;
      $display("FAIL flush lvl=%0d vld=%b rdy=%b exp 0/0/1",
               Level, OutVld, InRdy);
    end
    InVld = 1'b1; InData = 10'h00C; tick(); InVld = 1'b0;
    tests_run++;
    if (OutVld !== 1'b1 || OutData !== 10'h00C || Level !== 3'd1) begin
      fails++;
      $display("FAIL flush_after vld=%b dat=%h lvl=%0d exp 1/00c/1",
               OutVld, OutData, Level);
    end
    drain();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_dat;
    for (int n = 0; n < 400; n++) begin
      InVld  = ($urandom_range(0, 99) < 60);
      OutRdy = ($urandom_range(0, 99) < 50);
      Flush  = ($urandom_range(0, 99) < 4);
      InData = W'($urandom);
      tick();
      exp_dat = (q.size() > 0) ? q[0] : '0;
      tests_run++;
      if (Level !== 3'(q.size()) || OutVld !== (q.size() > 0) ||
          InRdy !== (q.size() < DEPTH) || AlmostFull !== (q.size() >= AFT) ||
          OutData !== exp_dat) begin
        fails++;
        $display("FAIL rand_%0d lvl=%0d/%0d vld=%b rdy=%b af=%b dat=%h/%h",
                 n, Level, q.size(), OutVld, InRdy, AlmostFull, OutData, exp_dat);
      end
    end
    Flush = 1'b0; InVld = 1'b0; OutRdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_pop();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
